// File: rtl/mux_4to1_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1_rr_arb
// Purpose  : Four-channel round-robin arbitrating multiplexer with
//            valid/ready handshakes and packet locking. It merges four
//            streams into one registered output stream. Each output beat is
//            tagged with the index of its source channel.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i0..i3           - channel data (width bits each)
//            i_valid, i_last  - per-channel valid / end-of-packet flags
//            i_ready          - per-channel ready (combinational)
//            o, o_sel, o_last - registered output beat, source index, last
//            o_valid, o_ready - output handshake
// Revision : 1.0 - initial release
// ============================================================================
module mux_4to1_rr_arb #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] i0,
  input  logic [width-1:0] i1,
  input  logic [width-1:0] i2,
  input  logic [width-1:0] i3,
  input  logic [3:0]       i_valid,
  input  logic [3:0]       i_last,
  output logic [3:0]       i_ready,
  output logic [width-1:0] o,
  output logic [1:0]       o_sel,
  output logic             o_last,
  output logic             o_valid,
  input  logic             o_ready
);

  localparam logic [0:0] c_ARB  = 1'b0;
  localparam logic [0:0] c_LOCK = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       lock_ch_q, lock_ch_d;

  logic [width-1:0] o_q;
  logic [1:0]       o_sel_q;
  logic             o_last_q;
  logic             o_valid_q;

  logic             w_load;
  logic [1:0]       w_grant;
  logic             w_any;
  logic [1:0]       w_idx;
  logic             w_accept;
  logic [1:0]       w_acc_ch;
  logic [width-1:0] w_acc_data;

  // Output register may be written when empty or being drained this cycle.
  assign w_load = ~o_valid_q | o_ready;

  // Round-robin search starting at ptr; the first valid channel wins.
  always_comb begin
    w_grant = ptr_q;
    w_any   = 1'b0;
    w_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      w_idx = ptr_q + 2'(k);
      if (!w_any && i_valid[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
  end

  // In LOCK only the held channel is served, so the accepting channel is
  // either lock_ch or the arbitration winner.
  assign w_acc_ch = (state_q == c_LOCK) ? lock_ch_q : w_grant;
  assign w_accept = |(i_valid & i_ready);

  always_comb begin
    case (w_acc_ch)
      2'd0:    w_acc_data = i0;
      2'd1:    w_acc_data = i1;
      2'd2:    w_acc_data = i2;
      default: w_acc_data = i3;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_ARB;
      ptr_q     <= 2'd0;
      lock_ch_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // FSM: next state. A last beat always returns to ARB and advances the
  // pointer past the served channel; a non-last beat holds the channel.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_ch_d = lock_ch_q;
    if (w_accept) begin
      if (i_last[w_acc_ch]) begin
        state_d = c_ARB;
        ptr_d   = w_acc_ch + 2'd1;
      end else begin
        state_d   = c_LOCK;
        lock_ch_d = w_acc_ch;
      end
    end
  end

  // FSM: outputs. In LOCK the ready for the held channel follows load even
  // when that channel is not valid, so no other channel can slip in.
  always_comb begin
    i_ready = 4'b0000;
    if (!rst && w_load) begin
      case (state_q)
        c_ARB:   if (w_any) i_ready[w_grant] = 1'b1;
        default: i_ready[lock_ch_q] = 1'b1;
      endcase
    end
  end

  // Output register: loads on accept, empties on an unfilled drain, and
  // holds everything under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= '0;
      o_sel_q   <= 2'd0;
      o_last_q  <= 1'b0;
      o_valid_q <= 1'b0;
    end else if (w_load) begin
      if (w_accept) begin
        o_q       <= w_acc_data;
        o_sel_q   <= w_acc_ch;
        o_last_q  <= i_last[w_acc_ch];
        o_valid_q <= 1'b1;
      end else begin
        o_valid_q <= 1'b0;
      end
    end
  end

  assign o       = o_q;
  assign o_sel   = o_sel_q;
  assign o_last  = o_last_q;
  assign o_valid = o_valid_q;

endmodule
`default_nettype wire
